// File: rtl/button_debouncer.sv
// button_debouncer: synchronises and debounces a raw push-button, then emits
// single-cycle press / release strobes and a step strobe.
// Optional feature macro: BUTTON_DEBOUNCER_AUTO_REPEAT_EN
//   defined   -> step also fires REPEAT_DELAY cycles after a press, then every
//                REPEAT_PERIOD cycles while the button stays held
//   undefined -> step is identical to press, no repeat logic is built
// The release strobe port is named release_pulse because 'release' is a
// reserved word in SystemVerilog.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 2000000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic button_level,
    output logic press,
    output logic release_pulse,
    output logic step
);

    localparam int unsigned CNT_W = 24;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       deb_cnt;
    logic                   accept_c;
    logic                   rise_c;
    logic                   fall_c;

    // Synchroniser chain; the last stage is the only one the logic looks at.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A level change is accepted on the last of DEBOUNCE_CYCLES differing samples.
    always_comb begin
        accept_c = (sync_s != button_level) && (deb_cnt == DEB_LAST);
        rise_c   = accept_c && sync_s;
        fall_c   = accept_c && !sync_s;
    end

    // Debounce counter, accepted level and the press/release strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            deb_cnt       <= '0;
            button_level  <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            if (sync_s == button_level) begin
                deb_cnt <= '0;
            end else if (accept_c) begin
                deb_cnt      <= '0;
                button_level <= sync_s;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
            press         <= rise_c;
            release_pulse <= fall_c;
        end
    end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    rpt_state_t       state_q;
    rpt_state_t       state_d;
    logic [CNT_W-1:0] rpt_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_d;
    logic             step_d;

    // Repeat state, counter and step register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
            step      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            step      <= step_d;
        end
    end

    // Next-state and step decode; an accepted release overrides a terminal count.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        step_d    = 1'b0;
        case (state_q)
            IDLE: begin
                step_d = rise_c;
                if (rise_c) begin
                    state_d   = DELAY;
                    rpt_cnt_d = '0;
                end
            end
            DELAY: begin
                if (fall_c) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == DLY_LAST) begin
                    step_d    = 1'b1;
                    state_d   = REPEAT;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (fall_c) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == PER_LAST) begin
                    step_d    = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

`else

    logic unused_repeat_cfg;

    // Without auto-repeat, step simply mirrors the press strobe.
    assign step              = press;
    assign unused_repeat_cfg = ^{DLY_LAST, PER_LAST};

`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus pushes expected strobe
// events and level samples; a negedge monitor pops and compares them.
module tb_button_debouncer;

    localparam logic [2:0] EV_PS = 3'b101;  // {press, release, step}
    localparam logic [2:0] EV_S  = 3'b001;
    localparam logic [2:0] EV_R  = 3'b010;

    typedef struct {
        int       cyc;
        logic [2:0] strb;
        logic     lvl;
    } ev_t;

    typedef struct {
        int   cyc;
        logic lvl;
    } lv_t;

    logic clock;
    logic reset;
    logic button_raw;
    logic button_level;
    logic press;
    logic release_pulse;
    logic step;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;

    ev_t  sb_q[$];
    lv_t  lv_q[$];

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_raw   (button_raw),
        .button_level (button_level),
        .press        (press),
        .release_pulse(release_pulse),
        .step         (step)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [2:0] s, input logic l);
        ev_t e;
        e.cyc = c; e.strb = s; e.lvl = l;
        sb_q.push_back(e);
    endtask

    task automatic push_lv(input int c, input logic l);
        lv_t e;
        e.cyc = c; e.lvl = l;
        lv_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // Monitor: compare every strobe and every scheduled level sample.
    always @(negedge clock) begin
        logic [2:0] got;
        ev_t e;
        lv_t l;
        got = {press, release_pulse, step};
        if (got != 3'b000) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected cyc=%0d got=%b want=none", cyc, got);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || e.strb != got || e.lvl != button_level) begin
                    errors++;
                    $display("FAIL strobe_event cyc=%0d got=%b lvl=%b want cyc=%0d strb=%b lvl=%b",
                             cyc, got, button_level, e.cyc, e.strb, e.lvl);
                end
            end
        end
        if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL strobe_missing cyc=%0d got=none want strb=%b", e.cyc, e.strb);
        end
        if (lv_q.size() != 0 && lv_q[0].cyc <= cyc) begin
            l = lv_q.pop_front();
            checks++;
            if (l.cyc != cyc || button_level != l.lvl) begin
                errors++;
                $display("FAIL level_sample cyc=%0d got=%b want cyc=%0d lvl=%b",
                         cyc, button_level, l.cyc, l.lvl);
            end
        end
        if (done) begin
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL strobe_leftover got=%0d want=0", sb_q.size());
            end
            checks++;
            if (lv_q.size() != 0) begin
                errors++;
                $display("FAIL level_leftover got=%0d want=0", lv_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] bounce;

        // Reset held for 3 cycles with button released, then quiet.
        reset      = 1'b1;
        button_raw = 1'b0;
        push_lv(1, 1'b0);
        push_lv(2, 1'b0);
        push_lv(3, 1'b0);
        wait_to(3);
        reset = 1'b0;
        push_lv(10, 1'b0);
        push_lv(23, 1'b0);
        wait_to(24);

        // Bounce with 2-cycle highs never reaches the threshold.
        t      = cyc;
        bounce = 8'b0011_0011;
        for (int i = 0; i < 8; i++) begin
            button_raw = bounce[i];
            @(negedge clock);
        end
        button_raw = 1'b0;
        push_lv(t + 12, 1'b0);
        wait_to(t + 14);

        // Three stable samples: one short of acceptance.
        t          = cyc;
        button_raw = 1'b1;
        wait_to(t + 3);
        button_raw = 1'b0;
        push_lv(t + 10, 1'b0);
        wait_to(t + 12);

        // Exactly four stable samples: accepted, then released inside DELAY.
        t          = cyc;
        button_raw = 1'b1;
        push_ev(t + 6, EV_PS, 1'b1);
        push_ev(t + 10, EV_R, 1'b0);
        wait_to(t + 4);
        button_raw = 1'b0;
        push_lv(t + 8, 1'b1);
        push_lv(t + 12, 1'b0);
        wait_to(t + 14);

        // Clean press with repeats; release coincides with a repeat and wins.
        t          = cyc;
        button_raw = 1'b1;
        push_ev(t + 6, EV_PS, 1'b1);
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
        push_ev(t + 16, EV_S, 1'b1);
        push_ev(t + 19, EV_S, 1'b1);
`endif
        wait_to(t + 16);
        button_raw = 1'b0;
        push_ev(t + 22, EV_R, 1'b0);
        push_lv(t + 21, 1'b1);
        push_lv(t + 22, 1'b0);
        wait_to(t + 32);

        // Reset while held aborts; the held button re-presses afterwards.
        t          = cyc;
        button_raw = 1'b1;
        push_ev(t + 6, EV_PS, 1'b1);
        wait_to(t + 12);
        reset = 1'b1;
        push_lv(t + 13, 1'b0);
        push_lv(t + 14, 1'b0);
        wait_to(t + 14);
        reset = 1'b0;
        push_ev(t + 20, EV_PS, 1'b1);
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
        push_ev(t + 30, EV_S, 1'b1);
        push_ev(t + 33, EV_S, 1'b1);
        push_ev(t + 36, EV_S, 1'b1);
        push_ev(t + 39, EV_S, 1'b1);
`endif
        wait_to(t + 34);
        button_raw = 1'b0;
        push_ev(t + 40, EV_R, 1'b0);
        push_lv(t + 38, 1'b1);
        push_lv(t + 41, 1'b0);
        wait_to(t + 48);

        done = 1'b1;
    end

endmodule
